keccak_squeezer: RTL and testbench

- Read-side counterpart of the Keccak permutation datapath.
- Captures the rate portion of a 1600-bit permuted state and streams it out as 64-bit digest words over a valid/ready interface.
- When the requested output length exceeds one rate block, it requests a further permutation and continues squeezing from the new state (SHAKE-style extended output).
- Sits between the f-permutation controller and the hash output port.

---
 rtl/keccak_squeezer.sv | 144 ++++++++++++++
 tb/tb_keccak_squeezer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeezer.sv
// Streams the rate lanes of a permuted Keccak state as 64-bit words and requests further permutations for extended output.
// Optional KECCAK_SQUEEZE_BYTE_SWAP_EN: byte-reverse each emitted word (FIPS 202 byte order on a big-endian bus).
module keccak_squeezer #(
  parameter int RATE_WORDS = 9,
  parameter int OUT_WORDS  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1599:0] state_in,
  input  logic          state_valid,
  output logic          perm_req,
  input  logic          perm_done,
  output logic          busy,
  output logic [63:0]   out_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int BW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int CW = $clog2(OUT_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_PERM
  } state_t;

  state_t          state, next_state;
  logic [63:0]     lanes [RATE_WORDS];
  logic [BW-1:0]   blk_idx;
  logic [CW-1:0]   tot_cnt;

  logic            start;
  logic            reload;
  logic            xfer;
  logic            is_last;
  logic            blk_end;
  logic [63:0]     sel_lane;
  logic [63:0]     word_fmt;

  assign is_last  = (tot_cnt == CW'(OUT_WORDS - 1));
  assign blk_end  = (blk_idx == BW'(RATE_WORDS - 1));
  assign sel_lane = lanes[blk_idx];

`ifdef KECCAK_SQUEEZE_BYTE_SWAP_EN
  always_comb begin
    word_fmt = '0;
    for (int b = 0; b < 8; b++) begin
      word_fmt[8*b +: 8] = sel_lane[56-8*b +: 8];
    end
  end
`else
  assign word_fmt = sel_lane;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    reload     = 1'b0;
    xfer       = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    perm_req   = 1'b0;
    out_word   = '0;
    unique case (state)
      IDLE: begin
        if (state_valid) begin
          start      = 1'b1;
          next_state = STREAM;
        end
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_word  = word_fmt;
        out_last  = is_last;
        xfer      = out_ready;
        if (out_ready) begin
          if (is_last) begin
            next_state = IDLE;
          end else if (blk_end) begin
            next_state = WAIT_PERM;
          end
        end
      end
      WAIT_PERM: begin
        busy     = 1'b1;
        perm_req = 1'b1;
        if (perm_done) begin
          reload     = 1'b1;
          next_state = STREAM;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the lane buffer is reset explicitly so a cleared squeezer never exposes stale digest data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RATE_WORDS; i++) begin
        lanes[i] <= '0;
      end
      blk_idx <= '0;
      tot_cnt <= '0;
    end else begin
      if (start || reload) begin
        for (int i = 0; i < RATE_WORDS; i++) begin
          lanes[i] <= state_in[1599-64*i -: 64];
        end
      end
      if (start) begin
        tot_cnt <= '0;
      end else if (xfer) begin
        tot_cnt <= tot_cnt + CW'(1);
      end
      // A block wrap leaves blk_idx at the end; the reload zeroes it.
      if (start || reload) begin
        blk_idx <= '0;
      end else if (xfer && !blk_end) begin
        blk_idx <= blk_idx + BW'(1);
      end
    end
  end

  // Capacity lanes are never emitted.
  if (RATE_WORDS < 25) begin : g_cap
    logic unused_capacity;
    assign unused_capacity = ^state_in[1599-64*RATE_WORDS:0];
  end

endmodule

// File: tb/tb_keccak_squeezer.sv
// Directed self-checking bench for keccak_squeezer: a default 9/8 instance and a 9/12 extended-output instance.
module tb_keccak_squeezer;

  logic          clk = 1'b0;
  logic          reset;
  logic [1599:0] state_in;
  logic          sv_a, sv_b;
  logic          perm_done;
  logic          out_ready;

  logic          a_perm_req, a_busy, a_out_valid, a_out_last;
  logic [63:0]   a_out_word;
  logic          b_perm_req, b_busy, b_out_valid, b_out_last;
  logic [63:0]   b_out_word;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  keccak_squeezer #(.RATE_WORDS(9), .OUT_WORDS(8)) u_dut (
    .clk(clk), .reset(reset), .state_in(state_in), .state_valid(sv_a),
    .perm_req(a_perm_req), .perm_done(perm_done), .busy(a_busy),
    .out_word(a_out_word), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_last(a_out_last)
  );

  keccak_squeezer #(.RATE_WORDS(9), .OUT_WORDS(12)) u_ext (
    .clk(clk), .reset(reset), .state_in(state_in), .state_valid(sv_b),
    .perm_req(b_perm_req), .perm_done(perm_done), .busy(b_busy),
    .out_word(b_out_word), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_last(b_out_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1599:0] make_state(input logic [63:0] base);
    logic [1599:0] s;
    s = '0;
    for (int i = 0; i < 25; i++) s[1599-64*i -: 64] = base + 64'(i);
    return s;
  endfunction

  // Expected bus value of a lane in the current build.
  function automatic logic [63:0] exp_w(input logic [63:0] lane);
`ifdef KECCAK_SQUEEZE_BYTE_SWAP_EN
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[63-8*b -: 8] = lane[8*b +: 8];
    return r;
`else
    return lane;
`endif
  endfunction

  logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int   nxt;
  int   cyc;

  initial begin
    reset = 1'b0; state_in = '0; sv_a = 0; sv_b = 0; perm_done = 0; out_ready = 1;
    step(); step();
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_busy",  64'(a_busy), 64'd0);
    check("rst_word",  a_out_word, 64'd0);
    check("rst_preq",  64'(a_perm_req), 64'd0);
    reset = 1'b1;
    step(); step();

    // Plain squeeze, consumer always ready.
    state_in = make_state(64'd1);
    sv_a = 1; step(); sv_a = 0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("plain_valid%0d", k), 64'(a_out_valid), 64'd1);
      check($sformatf("plain_word%0d", k), a_out_word, exp_w(64'(k)));
      check($sformatf("plain_last%0d", k), 64'(a_out_last), 64'(k == 8));
      check($sformatf("plain_preq%0d", k), 64'(a_perm_req), 64'd0);
      step();
    end
    check("plain_busy_end", 64'(a_busy), 64'd0);
    check("plain_valid_end", 64'(a_out_valid), 64'd0);
    step();

    // Backpressure with a repeating ready pattern.
    sv_a = 1; step(); sv_a = 0;
    nxt = 1; cyc = 0;
    while (nxt <= 8 && cyc < 60) begin
      out_ready = pat[cyc % 7];
      check($sformatf("bp_valid_c%0d", cyc), 64'(a_out_valid), 64'd1);
      check($sformatf("bp_word_c%0d", cyc), a_out_word, exp_w(64'(nxt)));
      check($sformatf("bp_last_c%0d", cyc), 64'(a_out_last), 64'(nxt == 8));
      if (out_ready) nxt++;
      cyc++;
      step();
    end
    check("bp_accepted", 64'(nxt), 64'd9);
    check("bp_busy_end", 64'(a_busy), 64'd0);
    out_ready = 1;
    step();

    // Spurious state_valid mid-squeeze, then perm_done while idle.
    state_in = make_state(64'd1);
    sv_a = 1; step(); sv_a = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin
        state_in = make_state(64'hFF);
        sv_a = 1;
      end
      check($sformatf("spur_word%0d", k), a_out_word, exp_w(64'(k)));
      step();
      sv_a = 0;
    end
    check("spur_busy_end", 64'(a_busy), 64'd0);
    perm_done = 1; step(); perm_done = 0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("idle_pd_valid%0d", k), 64'(a_out_valid), 64'd0);
      check($sformatf("idle_pd_preq%0d", k), 64'(a_perm_req), 64'd0);
      check($sformatf("idle_pd_busy%0d", k), 64'(a_busy), 64'd0);
      step();
    end

    // Extended output: 12 words across two rate blocks.
    state_in = make_state(64'd1);
    sv_b = 1; step(); sv_b = 0;
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("ext_word%0d", k), b_out_word, exp_w(64'(k)));
      check($sformatf("ext_last%0d", k), 64'(b_out_last), 64'd0);
      step();
    end
    check("ext_wait_valid", 64'(b_out_valid), 64'd0);
    check("ext_wait_preq", 64'(b_perm_req), 64'd1);
    check("ext_wait_busy", 64'(b_busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("ext_hold_preq%0d", k), 64'(b_perm_req), 64'd1);
      check($sformatf("ext_hold_valid%0d", k), 64'(b_out_valid), 64'd0);
    end
    state_in = make_state(64'h100);
    perm_done = 1; step(); perm_done = 0;
    check("ext_preq_drop", 64'(b_perm_req), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ext2_valid%0d", k), 64'(b_out_valid), 64'd1);
      check($sformatf("ext2_word%0d", k), b_out_word, exp_w(64'h100 + 64'(k)));
      check($sformatf("ext2_last%0d", k), 64'(b_out_last), 64'(k == 2));
      step();
    end
    check("ext_busy_end", 64'(b_busy), 64'd0);
    check("ext_preq_end", 64'(b_perm_req), 64'd0);

    // Asynchronous reset while word 3 is stalled.
    state_in = make_state(64'd1);
    sv_a = 1; step(); sv_a = 0;
    step(); step();
    out_ready = 0;
    step();
    check("rst_stall_word", a_out_word, exp_w(64'd3));
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 64'(a_out_valid), 64'd0);
    check("arst_busy",  64'(a_busy), 64'd0);
    check("arst_preq",  64'(a_perm_req), 64'd0);
    check("arst_word",  a_out_word, 64'd0);
    step();
    reset = 1'b1;
    out_ready = 1;
    step();
    state_in = make_state(64'h20);
    sv_a = 1; step(); sv_a = 0;
    check("post_rst_word", a_out_word, exp_w(64'h20));
    check("post_rst_valid", 64'(a_out_valid), 64'd1);
    cyc = 0;
    while (a_busy && cyc < 20) begin step(); cyc++; end
    check("post_rst_drain", 64'(a_busy), 64'd0);

    // Byte-order check on lane 0.
    state_in = make_state(64'd0);
    state_in[1599 -: 64] = 64'h0011223344556677;
    sv_a = 1; step(); sv_a = 0;
`ifdef KECCAK_SQUEEZE_BYTE_SWAP_EN
    check("swap_word0", a_out_word, 64'h7766554433221100);
`else
    check("swap_word0", a_out_word, 64'h0011223344556677);
`endif
    cyc = 0;
    while (a_busy && cyc < 20) begin step(); cyc++; end
    check("swap_drain", 64'(a_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
